// File: rtl/vtg_pkg.sv
// Shared constants for the video timing generator: 640x480@60 timing,
// counter and pixel widths, and the colour-bar lookup.
// No ports; imported by vtg_delay and vtg_scheduler.
package vtg_pkg;

  // 640x480@60 (25.175 MHz pixel clock) timing
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int CNT_W = 12;
  localparam int RGB_W = 24;

  // Colour bars, left to right, {R,G,B}
  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_delay.sv
// Fixed-depth shift register with a reset value on every stage.
// Latency: DEPTH cycles (DEPTH = 0 is a straight wire).
// Backpressure: none; shifts every cycle.
// Ports: clk, rst_n (async active-low), din[WIDTH], dout[WIDTH].
module vtg_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stg [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
        end else begin
          stg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end

      assign dout = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vtg_scheduler.sv
// Video timing generator: runs h/v counters, requests pixels, aligns blank/sync with returned data.
// Latency: request to encoder outputs is DATA_LAT+1 cycles.
// Backpressure: none; en = 0 restarts the frame at (0,0) and drains blank into the pipeline.
// Ports: clk, rst_n, en | pix_req, pix_x, pix_y, frame_start (request side) |
//        rgb_in (data DATA_LAT cycles after pix_req) | blanking, hsync, vsync, rgb_out (encoders).
// Option: define VTG_PATTERN_EN to replace rgb_in with an internal 8-bar colour pattern.
module vtg_scheduler
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int DATA_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              frame_start,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic              blanking,
  output logic              hsync,
  output logic              vsync,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] hc, vc;
  logic             run;
  logic             hs_raw, vs_raw;
  logic             blank_d, hs_d, vs_d;
  logic [RGB_W-1:0] pix_dat;

  // Gating with rst_n keeps the request side quiet while reset is held,
  // even though the counters already sit at (0,0).
  assign run = en & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!en) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 12'd1;
    end else begin
      hc <= hc + 12'd1;
    end
  end

  assign pix_req     = run && (hc < H_ACT) && (vc < V_ACT);
  assign pix_x       = hc;
  assign pix_y       = vc;
  assign frame_start = run && (hc == '0) && (vc == '0);

  // vc only moves on the hc wrap, so vsync edges fall on hc == 0 naturally.
  assign hs_raw = run && (hc >= HS_START) && (hc < HS_END);
  assign vs_raw = run && (vc >= VS_START) && (vc < VS_END);

  // Delay line carries "asserted" flags; polarity is applied at the output register.
  vtg_delay #(
    .WIDTH   (3),
    .DEPTH   (DATA_LAT),
    .RST_VAL (3'b100)
  ) u_ctl_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({~pix_req, hs_raw, vs_raw}),
    .dout  ({blank_d, hs_d, vs_d})
  );

`ifdef VTG_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

  logic [CNT_W-1:0] x_d;
  logic [2:0]       bar_idx;

  vtg_delay #(
    .WIDTH   (CNT_W),
    .DEPTH   (DATA_LAT),
    .RST_VAL ('0)
  ) u_x_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (hc),
    .dout  (x_d)
  );

  // Only meaningful while x_d < H_ACTIVE; outside that the blank forces zero.
  assign bar_idx = 3'(x_d / BAR_W);
  assign pix_dat = bar_rgb(bar_idx);
`else
  assign pix_dat = rgb_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blanking <= 1'b1;
      hsync    <= ~H_POL;
      vsync    <= ~V_POL;
      rgb_out  <= '0;
    end else begin
      blanking <= blank_d;
      hsync    <= hs_d ? H_POL : ~H_POL;
      vsync    <= vs_d ? V_POL : ~V_POL;
      rgb_out  <= blank_d ? '0 : pix_dat;
    end
  end

endmodule

// File: tb/tb_vtg_scheduler.sv
// Randomized bench for vtg_scheduler on a shrunken raster so several frames fit.
// Latency under test: DATA_LAT = 2 (outputs DATA_LAT+1 cycles after the request).
// Backpressure: none; en is toggled randomly and reset is pulsed asynchronously.
module tb_vtg_scheduler;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int LAT = 2;
  localparam bit HP = 1'b0, VP = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        pix_req, frame_start, blanking, hsync, vsync;
  logic [11:0] pix_x, pix_y;
  logic [23:0] rgb_out;

  always #5 clk = ~clk;

  vtg_scheduler #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_POL    (HP), .V_POL (VP), .DATA_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .rgb_in      (rgb_in),
    .blanking    (blanking),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_out     (rgb_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raster position is just (enabled cycles since restart)
  // modulo the line/frame totals; a queue supplies the pipeline delay.
  typedef struct packed {
    logic        blank;
    logic        hs;
    logic        vs;
    logic [11:0] x;
  } sig_t;

  sig_t        sig_q[$];
  int          pos;
  logic        exp_blank, exp_hs, exp_vs;
  logic [23:0] exp_rgb;
  int          cyc = 0;
  int          last_fs = 0;
  bit          fs_ok = 0;

  function automatic sig_t idle_sig();
    sig_t s;
    s.blank = 1'b1; s.hs = 1'b0; s.vs = 1'b0; s.x = '0;
    return s;
  endfunction

  function automatic sig_t cur_sig(input logic run, input int p);
    sig_t s;
    int x, y;
    s = idle_sig();
    if (run) begin
      x = p % HT;
      y = (p / HT) % VT;
      s.blank = !(x < HA && y < VA);
      s.hs    = (x >= HA + HF) && (x < HA + HF + HS);
      s.vs    = (y >= VA + VF) && (y < VA + VF + VS);
      s.x     = 12'(x);
    end
    return s;
  endfunction

  function automatic logic [23:0] bar_colour(input int x);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[(x / (HA / 8)) % 8];
  endfunction

  task automatic model_reset();
    sig_q.delete();
    for (int i = 0; i < LAT; i++) sig_q.push_back(idle_sig());
    pos = 0;
    exp_blank = 1'b1; exp_hs = 1'b0; exp_vs = 1'b0; exp_rgb = '0;
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+4, advance model on the edge.
  task automatic step(input logic en_v, input logic [23:0] rgb_v);
    logic run;
    sig_t s, d;
    en = en_v;
    rgb_in = rgb_v;
    #3;
    run = rst_n && en;
    s = cur_sig(run, pos);
    chk("pix_req", 32'(pix_req), 32'(!s.blank));
    chk("frame_start", 32'(frame_start), 32'(run && (pos % FT == 0)));
    if (run) begin
      chk("pix_x", 32'(pix_x), 32'((pos % HT)));
      chk("pix_y", 32'(pix_y), 32'(((pos / HT) % VT)));
      if (frame_start) begin
        if (fs_ok) chk("fs_period", 32'(cyc - last_fs), 32'(FT));
        fs_ok = 1;
        last_fs = cyc;
      end
    end else begin
      fs_ok = 0;
    end
    chk("blanking", 32'(blanking), 32'(exp_blank));
    chk("hsync", 32'(hsync), 32'(exp_hs ? HP : !HP));
    chk("vsync", 32'(vsync), 32'(exp_vs ? VP : !VP));
    chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      sig_q.push_back(s);
      d = sig_q.pop_front();
      exp_blank = d.blank;
      exp_hs    = d.hs;
      exp_vs    = d.vs;
`ifdef VTG_PATTERN_EN
      exp_rgb   = d.blank ? 24'h0 : bar_colour(int'(d.x));
`else
      exp_rgb   = d.blank ? 24'h0 : rgb_v;
`endif
      pos = run ? pos + 1 : 0;
    end
    #1;
  endtask

  // Assert reset between edges and check the outputs respond without a clock.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_blanking", 32'(blanking), 32'(1));
    chk("rst_hsync", 32'(hsync), 32'(!HP));
    chk("rst_vsync", 32'(vsync), 32'(!VP));
    chk("rst_rgb", 32'(rgb_out), 32'(0));
    chk("rst_pix_req", 32'(pix_req), 32'(0));
    chk("rst_frame_start", 32'(frame_start), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    repeat (hold) step(1'b1, 24'($urandom));
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 24'($urandom));
    rst_n = 1'b1;

    // First request with a known pixel, then over two uninterrupted frames.
    step(1'b1, 24'h123456);
    repeat (2 * FT + 37) step(1'b1, 24'($urandom));

    // Reset mid-frame, then restart from (0,0).
    async_reset(2);
    repeat (FT / 2 + 5) step(1'b1, 24'($urandom));

    // en dropped at random points for short gaps.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(5, 60)) step(1'b1, 24'($urandom));
      repeat ($urandom_range(1, 6)) step(1'b0, 24'($urandom));
    end

    // Sparse random en drops.
    repeat (1500) step($urandom_range(0, 19) != 0, 24'($urandom));

    async_reset(1);
    repeat (FT + 10) step(1'b1, 24'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vtg_scheduler.md
Name: vtg_scheduler

Overview:
- Video timing generator and sequencer for the three TMDS channel encoders.
- Runs the horizontal/vertical counters and issues pixel requests to the pixel source.
- Delays blanking and sync so they land on the same cycle as the returned pixel data.
- Outputs per-cycle blanking, c0/c1 (hsync/vsync) and 24-bit RGB, registered and aligned, feeding the encoders directly.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- DATA_LAT, 2, pixel source read latency in cycles; legal range 0..7

Ports:
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 holds the block in its idle frame state
- pix_req  out  1  pixel request for (pix_x, pix_y)
- pix_x  out  12  requested column
- pix_y  out  12  requested row
- frame_start  out  1  one-cycle pulse with the request for (0,0)
- rgb_in  in  24  pixel data {R,G,B}; valid DATA_LAT cycles after pix_req
- blanking  out  1  to all encoders
- hsync  out  1  to channel-0 encoder c0
- vsync  out  1  to channel-0 encoder c1
- rgb_out  out  24  to the encoders; bits [23:16] R, [15:8] G, [7:0] B

Behaviour:
- Counters and totals
  - hc counts 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters (800).
  - vc counts 0..V_TOTAL-1, with V_TOTAL = sum of the V_* parameters (525).
  - hc wraps to 0 after H_TOTAL-1; vc increments on that wrap.
  - vc wraps to 0 after V_TOTAL-1, coincident with the hc wrap.
- Line and frame order: active, front porch, sync, back porch, for both lines and frames.
- Request stage (cycle t)
  - pix_req = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - pix_x = hc and pix_y = vc, both combinational from the counters.
  - frame_start = (hc == 0 && vc == 0 && en).
- Sync decode
  - Raw hsync is asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - Raw vsync is asserted for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - vsync edges coincide with hc == 0.
  - Asserted means driven at the level given by H_POL / V_POL.
- Alignment
  - Raw blank (= !pix_req), raw hsync and raw vsync pass through a DATA_LAT-deep delay line.
  - They are then registered together with rgb_in.
  - Response at cycle t+DATA_LAT+1: blanking/hsync/vsync/rgb_out for the request made at t.
  - Total latency from request to output is DATA_LAT+1 cycles.
- rgb_out during blanking: forced to 0; rgb_in is ignored while the delayed blank is 1.
- Reset (async, rst_n = 0)
  - hc = vc = 0; every delay-line stage holds blank = 1 and sync inactive.
  - blanking = 1; hsync = !H_POL; vsync = !V_POL; rgb_out = 0; pix_req = 0; frame_start = 0.
  - Reset asserted mid-frame takes effect immediately.
  - After release, the first request is (0,0) on the first edge with en = 1.
- en = 0
  - Counters are synchronously cleared to 0; pix_req = 0.
  - Blank = 1 and inactive sync are injected into the delay line, which drains within DATA_LAT+1 cycles.
  - When en goes 1, counting resumes at (0,0) with a frame_start pulse.
- DATA_LAT = 0: the delay line is bypassed and latency is 1 cycle.

Optional Feature:
- Macro: VTG_PATTERN_EN.
- Defined:
  - rgb_out comes from an internal 8-bar colour pattern indexed by the delayed column: bar = x / (H_ACTIVE/8).
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - rgb_in is ignored; pix_req, pix_x, pix_y and frame_start are still driven; latency is unchanged.
- Undefined: rgb_in passes through as described above.

Decomposition:
- Package vtg_pkg:
  - 640x480@60 timing constants.
  - Counter width constant (12).
  - RGB width constant (24).
  - Colour-bar lookup constants.
- Sub-module vtg_delay (parameters WIDTH, DEPTH, RST_VAL):
  - Async active-low reset shift register.
  - Used for the {blank, hsync, vsync} pipeline and, under VTG_PATTERN_EN, for pix_x.

Test Plan:
- Reset release then en = 1, DATA_LAT = 2, rgb_in = 0x123456 → pix_req = 1 at cycle 0 with (0,0) and frame_start = 1; at cycle 3 blanking = 0 and rgb_out = 0x123456.
- Full line → pix_req high for 640 cycles and low for 160; hsync low at delayed hc 656..751 and high elsewhere; rgb_out = 0 while blanking = 1.
- Full frame → vsync low only on lines 490–491, toggling at hc == 0; frame_start period is exactly 420000 cycles; second frame_start lands at (0,0).
- rst_n pulsed low at hc = 300, vc = 200 → outputs go to blanking = 1, syncs high, rgb_out = 0 without waiting for a clock edge; restart at (0,0).
- en dropped mid-line → pix_req = 0 next cycle; blanking = 1 within 3 cycles; re-enable produces frame_start plus request (0,0).
- VTG_PATTERN_EN, x = 0 / 80 / 639 → rgb_out = FFFFFF / FFFF00 / 000000.
